// File: rtl/mic_i2s_capture.sv
// ---------------------------------------------------------------------------
// mic_i2s_capture
//
// Four-microphone I2S capture front end for the mic DMA writer. Generates the
// I2S bit clock and word select for two stereo data lines, deserializes one
// MSB-first sample per mic per frame and holds the completed four-word frame
// in an output bank that the DMA reads combinationally by mic index.
//
// Parameters:
//   CLK_DIV      CLK cycles per SCK half-period (>= 2)
//   SAMPLE_BITS  valid bits per 32-bit slot (1..31), sign-extended on output
//
// Ports:
//   CLK, RESET      system clock, synchronous active-high reset
//   enable          capture enable; low holds SCK/WS low, drops partial frame
//   i2s_sck, i2s_ws generated bit clock / word select (0 = left slot)
//   i2s_sd0/1       serial data: sd0 = mic1 (L) / mic2 (R), sd1 = mic3 / mic4
//   select          DMA mic index 1..4 (other codes read as zero)
//   mic_data        selected bank word, combinational from select
//   read_ready      a frame is held and not yet acknowledged
//   frame_ack       one-cycle pulse, DMA has consumed the frame
//   overrun         sticky: a completed frame was dropped
//   overrun_count   saturating count of dropped frames
//
// Optional build macro MIC_TEST_PATTERN_EN adds input test_mode; while it is
// high a completing frame loads word n = {n, frame_cnt} instead of samples.
// ---------------------------------------------------------------------------
module mic_i2s_capture #(
    parameter int CLK_DIV     = 16,
    parameter int SAMPLE_BITS = 24
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        enable,
`ifdef MIC_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    output logic        i2s_sck,
    output logic        i2s_ws,
    input  logic        i2s_sd0,
    input  logic        i2s_sd1,
    input  logic [2:0]  select,
    output logic [31:0] mic_data,
    output logic        read_ready,
    input  logic        frame_ack,
    output logic        overrun,
    output logic [15:0] overrun_count
);

    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [4:0]       SB_IDX   = 5'(SAMPLE_BITS);

    // Replicate bit SAMPLE_BITS-1 into all higher bits of the slot word.
    function automatic logic [31:0] sign_extend(input logic [31:0] raw);
        logic [31:0] upper_s;
        upper_s = 32'hFFFF_FFFF << SAMPLE_BITS;
        if (raw[SAMPLE_BITS-1]) begin
            sign_extend = raw | upper_s;
        end else begin
            sign_extend = raw & ~upper_s;
        end
    endfunction

    logic [DIV_W-1:0] div_r;
    logic             sck_r;
    logic             ws_r;
    logic [4:0]       bit_r;
    logic [31:0]      sh0_r;
    logic [31:0]      sh1_r;
    logic [31:0]      stage0_r;
    logic [31:0]      stage1_r;
    logic             frame_done_r;
    logic [31:0]      bank_r [4];
    logic             ready_r;
    logic             ovr_r;
    logic [15:0]      ovr_cnt_r;

    logic             tc_s;
    logic             rise_s;
    logic             fall_s;
    logic             in_window_s;
    logic             load_s;
    logic             drop_s;
    logic [31:0]      captured_s [4];
    logic [31:0]      bank_next_s [4];
    logic [31:0]      mic_data_s;

    // SCK edge events and the capture window (bits 1..SAMPLE_BITS of a slot).
    always_comb begin
        tc_s        = (div_r == DIV_LAST);
        rise_s      = tc_s & ~sck_r;
        fall_s      = tc_s & sck_r;
        in_window_s = (bit_r >= 5'd1) && (bit_r <= SB_IDX);
    end

    // SCK/WS generation, deserializers and left-slot staging.
    always_ff @(posedge CLK) begin
        if (RESET || !enable) begin
            div_r        <= '0;
            sck_r        <= 1'b0;
            ws_r         <= 1'b0;
            bit_r        <= 5'd0;
            sh0_r        <= 32'h0;
            sh1_r        <= 32'h0;
            stage0_r     <= 32'h0;
            stage1_r     <= 32'h0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            if (tc_s) begin
                div_r <= '0;
                sck_r <= ~sck_r;
            end else begin
                div_r <= div_r + DIV_W'(1);
            end
            if (fall_s) begin
                bit_r <= bit_r + 5'd1;
                if (bit_r == 5'd31) begin
                    ws_r <= ~ws_r;
                end
            end
            // Bit 0 of each slot is the I2S one-bit delay and is skipped.
            if (rise_s && in_window_s) begin
                sh0_r <= {sh0_r[30:0], i2s_sd0};
                sh1_r <= {sh1_r[30:0], i2s_sd1};
                if (bit_r == SB_IDX) begin
                    if (!ws_r) begin
                        stage0_r <= {sh0_r[30:0], i2s_sd0};
                        stage1_r <= {sh1_r[30:0], i2s_sd1};
                    end else begin
                        // Right words stay in the shifters until the next
                        // left slot, so the bank copies them next cycle.
                        frame_done_r <= 1'b1;
                    end
                end
            end
        end
    end

    // Sign-extended captured words in mic order.
    always_comb begin
        captured_s[0] = sign_extend(stage0_r);
        captured_s[1] = sign_extend(sh0_r);
        captured_s[2] = sign_extend(stage1_r);
        captured_s[3] = sign_extend(sh1_r);
    end

`ifdef MIC_TEST_PATTERN_EN
    logic [23:0] frame_cnt_r;

    // Completed-frame counter, dropped frames included; wraps.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            frame_cnt_r <= 24'h0;
        end else if (frame_done_r) begin
            frame_cnt_r <= frame_cnt_r + 24'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    // Bank load source: test pattern or captured samples.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (test_mode) begin
                bank_next_s[i] = {8'(i + 1), frame_cnt_r};
            end else begin
                bank_next_s[i] = captured_s[i];
            end
        end
    end
`else
    // Bank load source: captured samples.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bank_next_s[i] = captured_s[i];
        end
    end
`endif

    // A completing frame loads unless the previous one is still unacknowledged.
    always_comb begin
        load_s = frame_done_r && (!ready_r || frame_ack);
        drop_s = frame_done_r && ready_r && !frame_ack;
    end

    // Output bank, read handshake and overrun bookkeeping.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 4; i++) begin
                bank_r[i] <= 32'h0;
            end
            ready_r   <= 1'b0;
            ovr_r     <= 1'b0;
            ovr_cnt_r <= 16'h0;
        end else if (load_s) begin
            for (int i = 0; i < 4; i++) begin
                bank_r[i] <= bank_next_s[i];
            end
            ready_r <= 1'b1;
        end else if (drop_s) begin
            ovr_r <= 1'b1;
            if (ovr_cnt_r != 16'hFFFF) begin
                ovr_cnt_r <= ovr_cnt_r + 16'd1;
            end
        end else if (ready_r && frame_ack) begin
            ready_r <= 1'b0;
        end
    end

    // DMA read mux, combinational by mic index.
    always_comb begin
        case (select)
            3'd1:    mic_data_s = bank_r[0];
            3'd2:    mic_data_s = bank_r[1];
            3'd3:    mic_data_s = bank_r[2];
            3'd4:    mic_data_s = bank_r[3];
            default: mic_data_s = 32'h0;
        endcase
    end

    assign i2s_sck       = sck_r;
    assign i2s_ws        = ws_r;
    assign mic_data      = mic_data_s;
    assign read_ready    = ready_r;
    assign overrun       = ovr_r;
    assign overrun_count = ovr_cnt_r;

endmodule

// File: tb/tb_mic_i2s_capture.sv
// ---------------------------------------------------------------------------
// Self-checking bench for mic_i2s_capture (CLK_DIV=2, SAMPLE_BITS=24).
// The bench plays four I2S mics whose words come from a random table, keeps
// its own cycle count since enable, and predicts outputs from frame timing
// arithmetic plus the handshake/overrun rules.
// ---------------------------------------------------------------------------
module tb_mic_i2s_capture;
    localparam int          CD    = 2;
    localparam int          SB    = 24;
    localparam int          FRAME = 128 * CD;
    localparam int          KD0   = (32 + SB) * 2 * CD + CD;
    localparam logic [31:0] MASK  = (32'd1 << SB) - 32'd1;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        enable = 1'b0;
    logic        sd0;
    logic        sd1;
    logic [2:0]  select = 3'd0;
    logic        frame_ack = 1'b0;
    logic        sck;
    logic        ws;
    logic        read_ready;
    logic        overrun;
    logic [31:0] mic_data;
    logic [15:0] overrun_count;
`ifdef MIC_TEST_PATTERN_EN
    logic        test_mode = 1'b0;
`endif

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] gen_w [16][4];
    logic [31:0] exp_dir [8];
    int          k;
    int          drv_p, drv_f, drv_s, drv_b;
    logic [31:0] m_bank [4];
    logic        m_rr;
    logic        m_ovr;
    logic [15:0] m_cnt;
    logic [23:0] m_fcnt;

    mic_i2s_capture #(.CLK_DIV(CD), .SAMPLE_BITS(SB)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .enable        (enable),
`ifdef MIC_TEST_PATTERN_EN
        .test_mode     (test_mode),
`endif
        .i2s_sck       (sck),
        .i2s_ws        (ws),
        .i2s_sd0       (sd0),
        .i2s_sd1       (sd1),
        .select        (select),
        .mic_data      (mic_data),
        .read_ready    (read_ready),
        .frame_ack     (frame_ack),
        .overrun       (overrun),
        .overrun_count (overrun_count)
    );

    initial forever #5 CLK = ~CLK;

    function automatic logic [31:0] sext(input logic [31:0] w);
        int v;
        v = int'(w << (32 - SB));
        return 32'(v >>> (32 - SB));
    endfunction

    // Cycle k (counted from enable) in which a frame's last bit has been taken.
    function automatic bit is_completion(input int kk);
        return (kk >= KD0) && (((kk - KD0) % FRAME) == 0);
    endfunction

    function automatic logic [31:0] exp_word(input int kk, input int i);
        int f;
        f = (kk - KD0) / FRAME;
`ifdef MIC_TEST_PATTERN_EN
        if (test_mode) return {8'(i + 1), m_fcnt};
`endif
        return sext(gen_w[f % 16][i]);
    endfunction

    // Reference model: cycle count since enable plus frame/handshake rules.
    always @(posedge CLK) begin
        if (RESET) begin
            k      <= 0;
            m_rr   <= 1'b0;
            m_ovr  <= 1'b0;
            m_cnt  <= 16'h0;
            m_fcnt <= 24'h0;
            for (int i = 0; i < 4; i++) m_bank[i] <= 32'h0;
        end else begin
            k <= enable ? k + 1 : 0;
            if (is_completion(k)) begin
                if (!m_rr || frame_ack) begin
                    for (int i = 0; i < 4; i++) m_bank[i] <= exp_word(k, i);
                    m_rr <= 1'b1;
                end else begin
                    m_ovr <= 1'b1;
                    if (m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
                end
                m_fcnt <= m_fcnt + 24'd1;
            end else if (m_rr && frame_ack) begin
                m_rr <= 1'b0;
            end
        end
    end

    // Mic emulation: bit b of each slot carries word bit SB-b, others are junk.
    initial begin
        sd0 = 1'b0;
        sd1 = 1'b0;
        forever begin
            @(negedge CLK);
            drv_p = k / (2 * CD);
            drv_f = (drv_p / 64) % 16;
            drv_s = (drv_p / 32) % 2;
            drv_b = drv_p % 32;
            if (drv_b >= 1 && drv_b <= SB) begin
                sd0 = gen_w[drv_f][drv_s][SB - drv_b];
                sd1 = gen_w[drv_f][2 + drv_s][SB - drv_b];
            end else begin
                sd0 = 1'($urandom % 2);
                sd1 = 1'($urandom % 2);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic regen();
        for (int f = 0; f < 16; f++)
            for (int i = 0; i < 4; i++) gen_w[f][i] = 32'($urandom) & MASK;
    endtask

    task automatic wait_k(input int target, output bit ok);
        for (int n = 0; n < 4 * FRAME && k != target; n++) tick();
        ok = (k == target);
    endtask

    task automatic test_reset();
        RESET = 1'b1; enable = 1'b0; frame_ack = 1'b0; select = 3'd0;
        repeat (3) tick();
        tests_run++; if (sck !== 1'b0) begin tests_failed++; $display("FAIL reset_sck: got %b want 0", sck); end
        tests_run++; if (ws !== 1'b0) begin tests_failed++; $display("FAIL reset_ws: got %b want 0", ws); end
        tests_run++; if (read_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_rr: got %b want 0", read_ready); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_ovr: got %b want 0", overrun); end
        tests_run++; if (overrun_count !== 16'h0) begin tests_failed++; $display("FAIL reset_cnt: got %0d want 0", overrun_count); end
        for (int s = 1; s <= 4; s++) begin
            select = 3'(s); #1;
            tests_run++; if (mic_data !== 32'h0) begin tests_failed++; $display("FAIL reset_mic%0d: got %h want 0", s, mic_data); end
        end
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_capture_directed();
        int wave_err;
        bit seen;
        regen();
        gen_w[0][0] = 32'h800001; gen_w[0][1] = 32'h123456;
        gen_w[0][2] = 32'h7FFFFF; gen_w[0][3] = 32'hFFFFFF;
        exp_dir = '{32'h0, 32'hFF800001, 32'h00123456, 32'h007FFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0};
        enable = 1'b1; wave_err = 0; seen = 1'b0;
        for (int n = 0; n < 2 * KD0 && !seen; n++) begin
            tick();
            if (sck !== 1'((k / CD) % 2) || ws !== 1'((k / (64 * CD)) % 2)) wave_err++;
            if (read_ready === 1'b1) seen = 1'b1;
        end
        tests_run++; if (wave_err != 0) begin tests_failed++; $display("FAIL sck_ws_wave: got %0d bad cycles want 0", wave_err); end
        tests_run++; if (!seen || k != KD0 + 1) begin tests_failed++; $display("FAIL first_ready: got k=%0d seen=%b want k=%0d", k, seen, KD0 + 1); end
        for (int s = 0; s < 8; s++) begin
            select = 3'(s); #1;
            tests_run++; if (mic_data !== exp_dir[s]) begin tests_failed++; $display("FAIL directed_sel%0d: got %h want %h", s, mic_data, exp_dir[s]); end
        end
    endtask

    task automatic test_overrun();
        bit ok;
        wait_k(KD0 + 2 * FRAME + 1, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL ovr_wait: got k=%0d want %0d", k, KD0 + 2 * FRAME + 1); end
        tests_run++; if (read_ready !== 1'b1) begin tests_failed++; $display("FAIL ovr_rr: got %b want 1", read_ready); end
        tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        tests_run++; if (overrun_count !== 16'd2) begin tests_failed++; $display("FAIL ovr_count: got %0d want 2", overrun_count); end
        for (int s = 1; s <= 4; s++) begin
            select = 3'(s); #1;
            tests_run++; if (mic_data !== exp_dir[s]) begin tests_failed++; $display("FAIL ovr_hold_mic%0d: got %h want %h", s, mic_data, exp_dir[s]); end
        end
        frame_ack = 1'b1; tick(); frame_ack = 1'b0;
        tests_run++; if (read_ready !== 1'b0) begin tests_failed++; $display("FAIL ack_clears: got %b want 0", read_ready); end
        wait_k(KD0 + 3 * FRAME + 1, ok);
        tests_run++; if (!ok || read_ready !== 1'b1) begin tests_failed++; $display("FAIL after_ack_rr: got %b want 1", read_ready); end
        for (int s = 1; s <= 4; s++) begin
            select = 3'(s); #1;
            tests_run++; if (mic_data !== sext(gen_w[3][s - 1])) begin tests_failed++; $display("FAIL after_ack_mic%0d: got %h want %h", s, mic_data, sext(gen_w[3][s - 1])); end
        end
    endtask

    task automatic test_ack_at_completion();
        bit ok;
        wait_k(KD0 + 4 * FRAME, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL coinc_wait: got k=%0d want %0d", k, KD0 + 4 * FRAME); end
        frame_ack = 1'b1; tick(); frame_ack = 1'b0;
        tests_run++; if (read_ready !== 1'b1) begin tests_failed++; $display("FAIL coinc_rr: got %b want 1", read_ready); end
        tests_run++; if (overrun_count !== 16'd2) begin tests_failed++; $display("FAIL coinc_count: got %0d want 2", overrun_count); end
        for (int s = 1; s <= 4; s++) begin
            select = 3'(s); #1;
            tests_run++; if (mic_data !== sext(gen_w[4][s - 1])) begin tests_failed++; $display("FAIL coinc_mic%0d: got %h want %h", s, mic_data, sext(gen_w[4][s - 1])); end
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        bit seen;
        int pin_err;
        int rr_err;
        frame_ack = 1'b1; tick(); frame_ack = 1'b0;
        wait_k(2 * CD * (64 * 5 + 32 + 10), ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL drop_wait: got k=%0d", k); end
        enable = 1'b0; pin_err = 0; rr_err = 0;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (sck !== 1'b0 || ws !== 1'b0) pin_err++;
            if (read_ready !== 1'b0) rr_err++;
        end
        tests_run++; if (pin_err != 0) begin tests_failed++; $display("FAIL disabled_pins: got %0d bad cycles want 0", pin_err); end
        tests_run++; if (rr_err != 0) begin tests_failed++; $display("FAIL disabled_rr: got %0d bad cycles want 0", rr_err); end
        regen();
        enable = 1'b1; seen = 1'b0;
        for (int n = 0; n < 2 * KD0 && !seen; n++) begin
            tick();
            if (read_ready === 1'b1) seen = 1'b1;
        end
        tests_run++; if (!seen || k != KD0 + 1) begin tests_failed++; $display("FAIL reenable_ready: got k=%0d seen=%b want k=%0d", k, seen, KD0 + 1); end
        for (int s = 1; s <= 4; s++) begin
            select = 3'(s); #1;
            tests_run++; if (mic_data !== sext(gen_w[0][s - 1])) begin tests_failed++; $display("FAIL reenable_mic%0d: got %h want %h", s, mic_data, sext(gen_w[0][s - 1])); end
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        wait_k(KD0 + FRAME + 1, ok);
        tests_run++; if (!ok || overrun_count !== 16'd3) begin tests_failed++; $display("FAIL retained_count: got %0d want 3", overrun_count); end
        wait_k(KD0 + FRAME + 100, ok);
        RESET = 1'b1; tick();
        tests_run++; if (sck !== 1'b0 || ws !== 1'b0) begin tests_failed++; $display("FAIL midreset_pins: got sck=%b ws=%b want 0 0", sck, ws); end
        tests_run++; if (read_ready !== 1'b0 || overrun !== 1'b0) begin tests_failed++; $display("FAIL midreset_flags: got rr=%b ovr=%b want 0 0", read_ready, overrun); end
        tests_run++; if (overrun_count !== 16'h0) begin tests_failed++; $display("FAIL midreset_count: got %0d want 0", overrun_count); end
        for (int s = 1; s <= 4; s++) begin
            select = 3'(s); #1;
            tests_run++; if (mic_data !== 32'h0) begin tests_failed++; $display("FAIL midreset_mic%0d: got %h want 0", s, mic_data); end
        end
        RESET = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] want;
        RESET = 1'b1; tick(); regen(); RESET = 1'b0; enable = 1'b1;
        for (int n = 0; n < 6 * FRAME; n++) begin
            tick();
            frame_ack = is_completion(k) ? 1'($urandom % 2) : ($urandom % 64 == 0);
            select = 3'($urandom % 8);
            #1;
            want = (select >= 3'd1 && select <= 3'd4) ? m_bank[select - 3'd1] : 32'h0;
            tests_run++; if (read_ready !== m_rr) begin tests_failed++; $display("FAIL rand_rr k=%0d: got %b want %b", k, read_ready, m_rr); end
            tests_run++; if (overrun !== m_ovr || overrun_count !== m_cnt) begin tests_failed++; $display("FAIL rand_ovr k=%0d: got %b/%0d want %b/%0d", k, overrun, overrun_count, m_ovr, m_cnt); end
            tests_run++; if (mic_data !== want) begin tests_failed++; $display("FAIL rand_mic k=%0d sel=%0d: got %h want %h", k, select, mic_data, want); end
        end
        frame_ack = 1'b0;
    endtask

`ifdef MIC_TEST_PATTERN_EN
    task automatic test_pattern();
        bit ok;
        RESET = 1'b1; test_mode = 1'b1; tick(); RESET = 1'b0; enable = 1'b1;
        wait_k(KD0 + 1, ok);
        select = 3'd3; #1;
        tests_run++; if (!ok || mic_data !== 32'h03000000) begin tests_failed++; $display("FAIL pattern_f1: got %h want 03000000", mic_data); end
        frame_ack = 1'b1; tick(); frame_ack = 1'b0;
        wait_k(KD0 + FRAME + 1, ok);
        select = 3'd3; #1;
        tests_run++; if (!ok || mic_data !== 32'h03000001) begin tests_failed++; $display("FAIL pattern_f2: got %h want 03000001", mic_data); end
        test_mode = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_capture_directed();
        test_overrun();
        test_ack_at_completion();
        test_enable_drop();
        test_reset_midframe();
        test_random();
`ifdef MIC_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
